// File: rtl/jogador_automatico_if.sv
// Bus between the memory-game automatic player and its surroundings.
// master drives the player's inputs (bench / game glue); slave is the player itself.
interface jogador_automatico_if #(
    parameter int ADDR_W = 4
);
    logic [3:0]        leds_i;
    logic              gravar_i;
    logic              limpa_i;
    logic              reproduzir_i;
    logic              injeta_erro_i;
    logic [ADDR_W-1:0] erro_pos_i;
    logic [3:0]        botoes_o;
    logic              ocupado_o;
    logic              fim_o;
    logic              cheio_o;
    logic [ADDR_W:0]   db_quantidade_o;
    logic [3:0]        db_estado_o;

    modport master (
        output leds_i, gravar_i, limpa_i, reproduzir_i, injeta_erro_i, erro_pos_i,
        input  botoes_o, ocupado_o, fim_o, cheio_o, db_quantidade_o, db_estado_o
    );

    modport slave (
        input  leds_i, gravar_i, limpa_i, reproduzir_i, injeta_erro_i, erro_pos_i,
        output botoes_o, ocupado_o, fim_o, cheio_o, db_quantidade_o, db_estado_o
    );
endinterface

// File: rtl/jogador_automatico.sv
// Automatic player for the memory game: records symbols shown on the leds and
// replays them on botoes with fixed press/gap timing, optionally corrupting one.
module jogador_automatico #(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int PRESS_CYCLES = 5,
    parameter int GAP_CYCLES   = 5
) (
    input logic              clk,
    input logic              rst,
    jogador_automatico_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSIONA = 2'd1,
        SOLTA     = 2'd2,
        FIM       = 2'd3
    } estado_t;

    localparam int MAX_CYCLES = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
    localparam int TIMER_W    = $clog2(MAX_CYCLES + 1);

    localparam logic [TIMER_W-1:0] PRESS_LAST = TIMER_W'(PRESS_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LAST   = TIMER_W'(GAP_CYCLES - 1);
    localparam logic [ADDR_W:0]    FULL_QTD   = (ADDR_W + 1)'(DEPTH);

    estado_t             estado_q, estado_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [ADDR_W:0]     index_q, index_d;
    logic [ADDR_W:0]     quantidade_q, quantidade_d;
    logic [3:0]          leds_prev_q;
    logic [3:0]          botoes_q, botoes_d;
    logic                ocupado_q, ocupado_d;
    logic                fim_q, fim_d;

    logic [3:0]          mem [DEPTH];
    logic                wr_en;
    logic                cheio;
    logic [3:0]          mem_rd;
    logic [3:0]          sym;

    assign cheio  = (quantidade_q == FULL_QTD);
    assign mem_rd = mem[index_q[ADDR_W-1:0]];
    // Rotate-left keeps a zero symbol at zero, so an empty slot can never turn into a press.
    assign sym    = (bus.injeta_erro_i && (index_q[ADDR_W-1:0] == bus.erro_pos_i))
                  ? {mem_rd[2:0], mem_rd[3]} : mem_rd;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        estado_d     = estado_q;
        timer_d      = timer_q;
        index_d      = index_q;
        quantidade_d = quantidade_q;
        wr_en        = 1'b0;
        botoes_d     = 4'd0;
        ocupado_d    = (estado_q == PRESSIONA) || (estado_q == SOLTA);
        fim_d        = (estado_q == FIM);

        case (estado_q)
            IDLE: begin
                if (bus.limpa_i) begin
                    quantidade_d = '0;
                end else if (bus.reproduzir_i) begin
                    index_d  = '0;
                    timer_d  = '0;
                    estado_d = (quantidade_q == '0) ? FIM : PRESSIONA;
                end else if (bus.gravar_i && (bus.leds_i != 4'd0) && (leds_prev_q == 4'd0)
                             && !cheio) begin
                    wr_en        = 1'b1;
                    quantidade_d = quantidade_q + 1'b1;
                end
            end
            PRESSIONA: begin
                botoes_d = sym;
                if (timer_q == PRESS_LAST) begin
                    timer_d  = '0;
                    estado_d = SOLTA;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            SOLTA: begin
                if (timer_q == GAP_LAST) begin
                    timer_d  = '0;
                    index_d  = index_q + 1'b1;
                    estado_d = ((index_q + 1'b1) == quantidade_q) ? FIM : PRESSIONA;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            FIM: begin
                estado_d = IDLE;
            end
            default: begin
                estado_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q     <= IDLE;
            timer_q      <= '0;
            index_q      <= '0;
            quantidade_q <= '0;
            leds_prev_q  <= 4'd0;
            botoes_q     <= 4'd0;
            ocupado_q    <= 1'b0;
            fim_q        <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            timer_q      <= timer_d;
            index_q      <= index_d;
            quantidade_q <= quantidade_d;
            leds_prev_q  <= bus.leds_i;
            botoes_q     <= botoes_d;
            ocupado_q    <= ocupado_d;
            fim_q        <= fim_d;
        end
    end

    // NOTE: the symbol buffer is deliberately not reset; quantidade_q alone says what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[quantidade_q[ADDR_W-1:0]] <= bus.leds_i;
        end
    end

    assign bus.botoes_o        = botoes_q;
    assign bus.ocupado_o       = ocupado_q;
    assign bus.fim_o           = fim_q;
    assign bus.cheio_o         = cheio;
    assign bus.db_quantidade_o = quantidade_q;
    assign bus.db_estado_o     = {2'b00, estado_q};
endmodule
